// File: rtl/log_comp_sched_pkg.sv
// Shared definitions for the log-compression scheduler slice.
// Holds the scheduler FSM state encoding, the default channel and width
// parameters, and the channel-tag width helper used by every file that
// has to size a channel index.
package log_comp_sched_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_LOG_WIDTH  = 16;
    localparam int DEF_COMP_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // Channel-tag width; kept at least 1 bit so tags are never zero-width.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/log_comp_sched_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   req        - request vector, one bit per channel
//   last_grant - index of the channel served most recently
//   grant      - one-hot grant (zero when no request)
//   grant_idx  - binary index of the granted channel
//   any_req    - at least one request is present
// The search starts at last_grant+1 and wraps modulo N, so the most
// recently served channel has the lowest priority.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_req
);

    logic [W:0]   sum;
    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            // last_grant < N and i <= N, so one subtraction wraps the sum.
            sum = {1'b0, last_grant} + (W+1)'(i);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            idx = sum[W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/log_comp_sched.sv
// Scheduler that shares one log-compression stage among NUM_CH channels.
// One sample is in flight at a time: ARB picks a channel round-robin and
// captures its sample, ISSUE hands it to the compressor, WAIT collects the
// compressed result, DELIVER presents it downstream tagged with its channel.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   ch_valid/ch_data/ch_ready   - per-channel request side
//   cmp_in_valid/ready/log_in   - sample to the compressor
//   cmp_out_valid/ready/comp_out- result from the compressor
//   out_valid/ready/data/ch     - tagged result downstream
//   busy                        - high in every state except ARB
//   grant_count                 - samples delivered, wraps at 2^16
//   fsm_state                   - current FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and its payload stable until that edge.
module log_comp_sched
    import log_comp_sched_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int LOG_WIDTH  = DEF_LOG_WIDTH,
    parameter int COMP_WIDTH = DEF_COMP_WIDTH,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*LOG_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]           ch_ready,
    output logic                        cmp_in_valid,
    input  logic                        cmp_in_ready,
    output logic [LOG_WIDTH-1:0]        cmp_log_in,
    input  logic                        cmp_out_valid,
    output logic                        cmp_out_ready,
    input  logic [COMP_WIDTH-1:0]       cmp_comp_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [COMP_WIDTH-1:0]       out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic                        busy,
    output logic [15:0]                 grant_count,
    output state_t                      fsm_state
);

    state_t               state;
    state_t               next_state;
    logic [CH_W-1:0]      last_grant;
    logic [CH_W-1:0]      cur_ch;
    logic [LOG_WIDTH-1:0] sample;
    logic [NUM_CH-1:0]    grant;
    logic [CH_W-1:0]      grant_idx;
    logic                 any_req;

    rr_arbiter #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_arb (
        .req        (ch_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_req    (any_req)
    );

    assign cmp_log_in = sample;
    assign fsm_state  = state;

    always_comb begin
        next_state    = state;
        ch_ready      = '0;
        cmp_in_valid  = 1'b0;
        cmp_out_ready = 1'b0;
        busy          = 1'b1;
        case (state)
            ST_ARB: begin
                busy = 1'b0;
                // No grant while reset is held: nothing is captured then.
                if (!reset) begin
                    ch_ready = grant;
                end
                if (any_req) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmp_in_valid = 1'b1;
                if (cmp_in_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cmp_out_ready = 1'b1;
                if (cmp_out_valid) begin
                    next_state = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (out_ready) begin
                    next_state = ST_ARB;
                end
            end
            default: next_state = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_ARB;
            last_grant  <= CH_W'(NUM_CH - 1);
            cur_ch      <= '0;
            sample      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            grant_count <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_ARB: begin
                    if (any_req) begin
                        sample <= ch_data[grant_idx*LOG_WIDTH +: LOG_WIDTH];
                        cur_ch <= grant_idx;
                    end
                end
                ST_WAIT: begin
                    if (cmp_out_valid) begin
                        out_data  <= cmp_comp_out;
                        out_ch    <= cur_ch;
                        out_valid <= 1'b1;
                    end
                end
                ST_DELIVER: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        last_grant  <= cur_ch;
                        grant_count <= grant_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_log_comp_sched.sv
// Directed testbench for log_comp_sched. A small compressor model returns
// the top byte of each accepted sample; an override path lets a test put a
// different value on the compressor result bus.
module tb_log_comp_sched;
    import log_comp_sched_pkg::*;

    localparam int NUM_CH = 4;
    localparam int LW     = 16;
    localparam int CW     = 8;
    localparam int CHW    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH*LW-1:0]    ch_data;
    logic [NUM_CH-1:0]       ch_ready;
    logic                    cmp_in_valid;
    logic                    cmp_in_ready;
    logic [LW-1:0]           cmp_log_in;
    logic                    cmp_out_valid;
    logic                    cmp_out_ready;
    logic [CW-1:0]           cmp_comp_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW-1:0]           out_data;
    logic [CHW-1:0]          out_ch;
    logic                    busy;
    logic [15:0]             grant_count;
    state_t                  fsm_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [CW-1:0] comp_q = '0;
    logic          ovr_en = 1'b0;
    logic [CW-1:0] ovr_val = '0;

    log_comp_sched #(
        .NUM_CH     (NUM_CH),
        .LOG_WIDTH  (LW),
        .COMP_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .cmp_in_valid  (cmp_in_valid),
        .cmp_in_ready  (cmp_in_ready),
        .cmp_log_in    (cmp_log_in),
        .cmp_out_valid (cmp_out_valid),
        .cmp_out_ready (cmp_out_ready),
        .cmp_comp_out  (cmp_comp_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .busy          (busy),
        .grant_count   (grant_count),
        .fsm_state     (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Compressor model: result is the top byte of the accepted sample.
    always @(posedge clk) begin
        if (cmp_in_valid && cmp_in_ready) comp_q <= cmp_log_in[LW-1:LW-8];
    end
    assign cmp_comp_out = ovr_en ? ovr_val : comp_q;

    // Driver tasks
    task automatic set_data(input int ch, input logic [LW-1:0] v);
        ch_data[ch*LW +: LW] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_out(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        ch_valid = 4'hF;
        cmp_in_ready = 1'b1;
        cmp_out_valid = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (ch_ready !== 4'h0) begin bad++; $display("FAIL rst_ch_ready: got %h expected 0", ch_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
        total++; if (cmp_in_valid !== 1'b0) begin bad++; $display("FAIL rst_cmp_in_valid: got %b expected 0", cmp_in_valid); end
        total++; if (cmp_log_in !== 16'h0) begin bad++; $display("FAIL rst_cmp_log_in: got %h expected 0", cmp_log_in); end
        total++; if (cmp_out_ready !== 1'b0) begin bad++; $display("FAIL rst_cmp_out_ready: got %b expected 0", cmp_out_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (grant_count !== 16'h0) begin bad++; $display("FAIL rst_grant_count: got %h expected 0", grant_count); end
        total++; if (fsm_state !== ST_ARB) begin bad++; $display("FAIL rst_state: got %0d expected %0d", fsm_state, ST_ARB); end
        ch_valid = 4'h0;
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [CHW-1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [CW-1:0]  exp_d  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        bit ok;
        set_data(0, 16'h1100); set_data(1, 16'h2200);
        set_data(2, 16'h3300); set_data(3, 16'h4400);
        cmp_in_ready = 1'b1; cmp_out_valid = 1'b1; out_ready = 1'b1;
        do_reset();
        ch_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_out(20, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL rr_timeout[%0d]: got no out_valid expected out_valid=1", i); end
            else begin
                if (out_ch !== exp_ch[i]) begin bad++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", i, out_ch, exp_ch[i]); end
                total++;
                if (out_data !== exp_d[i]) begin bad++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data, exp_d[i]); end
            end
        end
        ch_valid = 4'h0;
    endtask

    task automatic test_single_channel();
        int t [3];
        bit ok;
        set_data(2, 16'h5A00);
        cmp_in_ready = 1'b1; cmp_out_valid = 1'b1; out_ready = 1'b1;
        do_reset();
        ch_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            wait_out(20, ok);
            t[i] = cyc;
            total++;
            if (!ok) begin bad++; $display("FAIL single_timeout[%0d]: got no out_valid expected out_valid=1", i); end
            else begin
                if (out_ch !== 2'd2) begin bad++; $display("FAIL single_ch[%0d]: got %0d expected 2", i, out_ch); end
                total++;
                if (out_data !== 8'h5A) begin bad++; $display("FAIL single_data[%0d]: got %h expected 5a", i, out_data); end
            end
        end
        @(negedge clk);
        #1;
        total++; if (grant_count !== 16'd3) begin bad++; $display("FAIL single_count: got %0d expected 3", grant_count); end
        total++; if (t[1] - t[0] != 4) begin bad++; $display("FAIL single_gap1: got %0d expected 4", t[1] - t[0]); end
        total++; if (t[2] - t[1] != 4) begin bad++; $display("FAIL single_gap2: got %0d expected 4", t[2] - t[1]); end
        ch_valid = 4'h0;
    endtask

    task automatic test_issue_stall();
        bit ok;
        set_data(1, 16'h7700);
        cmp_in_ready = 1'b0; cmp_out_valid = 1'b1; out_ready = 1'b1;
        do_reset();
        ch_valid = 4'b0010;
        #1;
        total++; if (ch_ready !== 4'b0010) begin bad++; $display("FAIL stall_grant: got %b expected 0010", ch_ready); end
        @(negedge clk);
        // Changing the source after the grant must not reach the compressor.
        set_data(1, 16'h9900);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (cmp_in_valid !== 1'b1 || cmp_log_in !== 16'h7700 || ch_ready !== 4'h0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b log_in=%h ch_ready=%b expected valid=1 log_in=7700 ch_ready=0000",
                         i, cmp_in_valid, cmp_log_in, ch_ready);
            end
            @(negedge clk);
        end
        ch_valid = 4'h0;
        cmp_in_ready = 1'b1;
        wait_out(20, ok);
        total++;
        if (!ok || out_ch !== 2'd1 || out_data !== 8'h77) begin
            bad++;
            $display("FAIL stall_result: got ok=%b ch=%0d data=%h expected ok=1 ch=1 data=77", ok, out_ch, out_data);
        end
    endtask

    task automatic test_deliver_stall();
        bit ok;
        set_data(0, 16'hAB00);
        cmp_in_ready = 1'b1; cmp_out_valid = 1'b1; out_ready = 1'b0;
        do_reset();
        ch_valid = 4'b0001;
        wait_out(20, ok);
        total++;
        if (!ok || out_ch !== 2'd0 || out_data !== 8'hAB) begin
            bad++;
            $display("FAIL dstall_first: got ok=%b ch=%0d data=%h expected ok=1 ch=0 data=ab", ok, out_ch, out_data);
        end
        ch_valid = 4'h0;
        ovr_en = 1'b1;
        ovr_val = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'hAB || out_ch !== 2'd0 || cmp_out_ready !== 1'b0) begin
                bad++;
                $display("FAIL dstall_hold[%0d]: got valid=%b data=%h ch=%0d cmp_out_ready=%b expected 1 ab 0 0",
                         i, out_valid, out_data, out_ch, cmp_out_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || grant_count !== 16'd1) begin
            bad++;
            $display("FAIL dstall_release: got valid=%b count=%0d expected valid=0 count=1", out_valid, grant_count);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        set_data(3, 16'h1234);
        set_data(0, 16'h4200);
        cmp_in_ready = 1'b1; cmp_out_valid = 1'b0; out_ready = 1'b1;
        do_reset();
        ch_valid = 4'b1000;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (fsm_state !== ST_WAIT || cmp_out_ready !== 1'b1) begin
            bad++;
            $display("FAIL rwait_reach: got state=%0d cmp_out_ready=%b expected state=%0d 1", fsm_state, cmp_out_ready, ST_WAIT);
        end
        reset = 1'b1;
        ch_valid = 4'hF;
        @(negedge clk);
        #1;
        total++;
        if (fsm_state !== ST_ARB || out_valid !== 1'b0 || cmp_in_valid !== 1'b0 || cmp_out_ready !== 1'b0 ||
            ch_ready !== 4'h0 || busy !== 1'b0 || cmp_log_in !== 16'h0 || out_data !== 8'h0 ||
            out_ch !== 2'd0 || grant_count !== 16'h0) begin
            bad++;
            $display("FAIL rwait_clear: got state=%0d ov=%b civ=%b cor=%b chr=%b busy=%b log=%h od=%h och=%0d gc=%0d expected all zero",
                     fsm_state, out_valid, cmp_in_valid, cmp_out_ready, ch_ready, busy, cmp_log_in, out_data, out_ch, grant_count);
        end
        reset = 1'b0;
        #1;
        total++; if (ch_ready !== 4'b0001) begin bad++; $display("FAIL rwait_grant: got %b expected 0001", ch_ready); end
        cmp_out_valid = 1'b1;
        wait_out(20, ok);
        ch_valid = 4'h0;
        total++;
        if (!ok || out_ch !== 2'd0 || out_data !== 8'h42) begin
            bad++;
            $display("FAIL rwait_result: got ok=%b ch=%0d data=%h expected ok=1 ch=0 data=42", ok, out_ch, out_data);
        end
    endtask

    task automatic test_count_wrap();
        logic [15:0] exp_c [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        bit ok;
        cmp_in_ready = 1'b1; cmp_out_valid = 1'b1; out_ready = 1'b1;
        do_reset();
        // Preload the counter near its top instead of delivering 65534 samples.
        force dut.grant_count = 16'hFFFE;
        @(negedge clk);
        release dut.grant_count;
        set_data(1, 16'h3C00);
        ch_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            wait_out(20, ok);
            @(negedge clk);
            #1;
            total++;
            if (!ok || grant_count !== exp_c[i]) begin
                bad++;
                $display("FAIL wrap_count[%0d]: got ok=%b count=%h expected ok=1 count=%h", i, ok, grant_count, exp_c[i]);
            end
        end
        ch_valid = 4'h0;
    endtask

    initial begin
        reset = 1'b1;
        ch_valid = '0;
        ch_data = '0;
        cmp_in_ready = 1'b0;
        cmp_out_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single_channel();
        test_issue_stall();
        test_deliver_stall();
        test_reset_in_wait();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/log_comp_sched.md
LOG_COMP_SCHED -- requirements
Module: log_comp_sched

Interface
REQ-001 Parameter NUM_CH, default 4: number of channel requesters sharing one log-compression stage (≥2).
REQ-002 Parameter LOG_WIDTH, default 16: log-domain sample width.
REQ-003 Parameter COMP_WIDTH, default 8: compressed sample width.
REQ-004 Derived constant CH_W = clog2(NUM_CH): channel-tag width.
REQ-005 Clock and reset SHALL be as follows: reset reset, synchronous, active-high; clock clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 ch_valid  input  NUM_CH  per-channel sample valid.
REQ-009 ch_data  input  NUM_CH*LOG_WIDTH  per-channel samples; channel i occupies bits [i*LOG_WIDTH +: LOG_WIDTH].
REQ-010 ch_ready  output  NUM_CH  per-channel accept; one-hot or zero.
REQ-011 cmp_in_valid  output  1  sample valid to the compressor.
REQ-012 cmp_in_ready  input  1  compressor accept.
REQ-013 cmp_log_in  output  LOG_WIDTH  sample to the compressor.
REQ-014 cmp_out_valid  input  1  compressor result valid.
REQ-015 cmp_out_ready  output  1  scheduler accepts the compressor result.
REQ-016 cmp_comp_out  input  COMP_WIDTH  compressor result.
REQ-017 out_valid  output  1  tagged result valid downstream.
REQ-018 out_ready  input  1  downstream accept.
REQ-019 out_data  output  COMP_WIDTH  compressed sample.
REQ-020 out_ch  output  CH_W  source channel of out_data.
REQ-021 busy  output  1  high in every state except ARB.
REQ-022 grant_count  output  16  total samples delivered; wraps modulo 2^16.

Function
REQ-023 FSM states SHALL be ARB, ISSUE, WAIT and DELIVER; at most one sample is in flight at any time.
REQ-024 ARB: when any ch_valid is high, the scheduler SHALL select channel g round-robin, searching from last_grant+1 modulo NUM_CH.
- ch_ready[g] is driven combinationally high in the same cycle.
- ch_data[g] is captured and cur_ch <= g.
- Next state is ISSUE.
REQ-025 ARB with no ch_valid high: ch_ready SHALL be all zero and the FSM SHALL remain in ARB.
REQ-026 ISSUE: cmp_in_valid SHALL be 1 with the captured sample on cmp_log_in; on cmp_in_ready the FSM SHALL go to WAIT.
- cmp_in_valid and cmp_log_in stay stable until that handshake.
REQ-027 WAIT: cmp_out_ready SHALL be 1; on cmp_out_valid, out_data <= cmp_comp_out, out_ch <= cur_ch, out_valid <= 1, and the FSM SHALL go to DELIVER.
REQ-028 cmp_out_ready SHALL be 0 outside WAIT; a cmp_out_valid pulse outside WAIT SHALL be ignored.
REQ-029 DELIVER: out_valid, out_data and out_ch SHALL hold stable until out_ready. On out_ready:
- out_valid <= 0, last_grant <= cur_ch, grant_count increments.
- Next state is ARB.
REQ-030 ch_ready SHALL be all zero in ISSUE, WAIT and DELIVER; new requests wait and are not dropped.
REQ-031 Minimum occupancy SHALL be 4 cycles per sample, one in each state, when cmp_in_ready, cmp_out_valid and out_ready respond immediately.
REQ-032 A channel that is the sole requester SHALL be granted on consecutive rounds with no idle cycle beyond REQ-031.
REQ-033 Changes to ch_valid or ch_data outside the ARB grant cycle SHALL NOT affect the sample in flight.

Reset
REQ-034 On reset, all of the following SHALL be 0: out_valid, out_data, out_ch, cmp_in_valid, cmp_log_in, cmp_out_ready, ch_ready, busy, grant_count.
REQ-035 On reset, state SHALL be ARB and last_grant SHALL be NUM_CH-1, so channel 0 wins first.
REQ-036 Reset in any state SHALL discard the in-flight sample; the compressor is reset by the same reset signal.

Structure
REQ-037 The shared package SHALL hold the FSM state encoding, the NUM_CH, LOG_WIDTH and COMP_WIDTH defaults, and the CH_W function.
REQ-038 Round-robin selection SHALL be a sub-module rr_arbiter.
- Inputs: request vector and last_grant.
- Outputs: one-hot grant, grant index and any_req.
- Purely combinational.

Verification
REQ-039 Hold all four ch_valid high with distinct data 0x1100, 0x2200, 0x3300, 0x4400 -> out_ch sequence 0,1,2,3,0 with out_data 0x11, 0x22, 0x33, 0x44, assuming the compressor returns the top byte.
REQ-040 Only channel 2 valid for 3 samples -> out_ch = 2 three times, grant_count = 3, and samples spaced 4 cycles apart.
REQ-041 cmp_in_ready low for 5 cycles in ISSUE -> cmp_log_in stable for those cycles, ch_ready = 0 throughout, and no sample lost.
REQ-042 out_ready low for 10 cycles in DELIVER -> out_valid, out_data and out_ch held; a spurious cmp_out_valid in that window is ignored.
REQ-043 Reset asserted in WAIT -> next cycle all outputs 0, state ARB, and the next grant goes to channel 0.
REQ-044 Deliver 65536 samples -> grant_count wraps to 0.
